// File: rtl/hv_ngram_enc.sv
// rtl/hv_ngram_enc.sv - hypervector n-gram encoder with item memory and majority bundling
module hv_ngram_enc #(
  parameter  int DIM      = 32,
  parameter  int N_MAX    = 4,
  parameter  int IM_DEPTH = 128,
  parameter  int CNT_W    = 8,
  localparam int AW       = $clog2(IM_DEPTH),
  localparam int NW       = $clog2(N_MAX) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NW-1:0]  cfg_n,
  input  logic           im_we,
  input  logic [AW-1:0]  im_addr,
  input  logic [DIM-1:0] im_wdata,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [AW-1:0]  s_data,
  input  logic           s_last,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [DIM-1:0] m_data,
  output logic           m_err,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, ACC, THRESH, OUT} state_t;

  state_t           state, state_nx;
  logic             s_hs;
  logic             last_seen;
  logic             rec_done;
  logic [DIM-1:0]   mem [IM_DEPTH];
  logic [DIM-1:0]   rd_data;
  logic             v1, l1, v2, l2;
  logic [DIM-1:0]   hist [N_MAX];
  logic [NW-1:0]    hist_cnt;
  logic [NW-1:0]    n_reg;
  logic [NW-1:0]    n_clamp;
  logic [CNT_W-1:0] cnt [DIM];
  logic [15:0]      ngram_cnt;
  logic [DIM-1:0]   ngram;
  logic [DIM-1:0]   rot_v;
  logic             ngram_fire;
  logic [DIM-1:0]   thresh;

  assign s_hs       = s_valid & s_ready;
  assign s_ready    = (state == IDLE) || ((state == ACC) && !last_seen);
  assign m_valid    = (state == OUT);
  assign busy       = (state != IDLE);
  assign rec_done   = (state == OUT) && m_ready;
  assign ngram_fire = v2 && (hist_cnt >= n_reg);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: record closes once the last symbol's n-gram has been counted
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (s_hs) state_nx = ACC;
      ACC:     if (v2 && l2) state_nx = THRESH;
      THRESH:  state_nx = OUT;
      OUT:     if (m_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Clamp requested n-gram length into 1..N_MAX
  always_comb begin
    n_clamp = cfg_n;
    if (cfg_n == '0)               n_clamp = NW'(1);
    else if (cfg_n > NW'(N_MAX))   n_clamp = NW'(N_MAX);
  end

  // Item memory: writes only while idle; read-before-write on the same edge
  always_ff @(posedge clk) begin
    if (im_we && (state == IDLE)) mem[im_addr] <= im_wdata;
    if (s_hs) rd_data <= mem[s_data];
  end

  // n-gram: XOR of history entries, entry k rotated left k times
  always_comb begin
    ngram = '0;
    rot_v = '0;
    for (int k = 0; k < N_MAX; k++) begin
      rot_v = hist[k];
      for (int j = 0; j < k; j++) rot_v = {rot_v[DIM-2:0], rot_v[DIM-1]};
      if (NW'(k) < n_reg) ngram = ngram ^ rot_v;
    end
  end

  // Majority threshold; ties resolve to 0
  always_comb begin
    thresh = '0;
    for (int i = 0; i < DIM; i++)
      thresh[i] = (17'({cnt[i], 1'b0}) > {1'b0, ngram_cnt});
  end

  // Symbol pipeline, history shift and saturating bundle counters
  always_ff @(posedge clk) begin
    if (rst || rec_done) begin
      v1        <= 1'b0;
      l1        <= 1'b0;
      v2        <= 1'b0;
      l2        <= 1'b0;
      last_seen <= 1'b0;
      hist_cnt  <= '0;
      ngram_cnt <= '0;
      for (int k = 0; k < N_MAX; k++) hist[k] <= '0;
      for (int i = 0; i < DIM; i++) cnt[i] <= '0;
      if (rst) n_reg <= NW'(1);
    end else begin
      v1 <= s_hs;
      l1 <= s_hs & s_last;
      v2 <= v1;
      l2 <= l1;
      if (s_hs && (state == IDLE)) n_reg <= n_clamp;
      if (s_hs && s_last) last_seen <= 1'b1;
      if (v1) begin
        hist[0] <= rd_data;
        for (int k = 1; k < N_MAX; k++) hist[k] <= hist[k-1];
        if (hist_cnt != NW'(N_MAX)) hist_cnt <= hist_cnt + NW'(1);
      end
      if (ngram_fire) begin
        for (int i = 0; i < DIM; i++)
          if (ngram[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
        if (ngram_cnt != 16'hFFFF) ngram_cnt <= ngram_cnt + 16'd1;
      end
    end
  end

  // Result register, loaded once in THRESH and held through OUT
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data <= '0;
      m_err  <= 1'b0;
    end else if (state == THRESH) begin
      m_data <= (ngram_cnt == 16'd0) ? '0 : thresh;
      m_err  <= (ngram_cnt == 16'd0);
    end
  end

endmodule

// File: tb/tb_hv_ngram_enc.sv
// tb/tb_hv_ngram_enc.sv - directed self-checking bench for hv_ngram_enc
module tb_hv_ngram_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cfg_n;
  logic        im_we;
  logic [6:0]  im_addr;
  logic [31:0] im_wdata;
  logic        s_valid;
  logic        s_ready;
  logic [6:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  hv_ngram_enc dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_n    (cfg_n),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_err    (m_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic write_im(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    im_we = 1'b1; im_addr = a; im_wdata = d;
    @(negedge clk);
    im_we = 1'b0;
  endtask

  // Sends nsym symbols (last one flagged), gap idle cycles between them,
  // then waits for m_valid; lat = rising edges after the last handshake.
  task automatic run_record(input int nsym, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [2:0] n,
                            input int gap, output logic [31:0] d, output logic e, output int lat);
    logic [6:0] syms [4];
    syms[0] = s0; syms[1] = s1; syms[2] = s2; syms[3] = s3;
    cfg_n = n;
    for (int i = 0; i < nsym; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = syms[i]; s_last = (i == nsym - 1);
      @(posedge clk);
      if (i != nsym - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          s_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    lat = 0;
    while (!m_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!m_valid) lat = -1;
    d = m_data;
    e = m_err;
  endtask

  task automatic accept_out;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data got %h exp 0", m_data); end
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL reset_m_err got %b exp 0", m_err); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
  endtask

  task automatic test_basic;
    logic [31:0] d; logic e; int lat;
    run_record(2, 7'd0, 7'd1, 7'd0, 7'd0, 3'd2, 0, d, e, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got %0d exp 3", lat); end
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL basic_data got %h exp 00000003", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", e); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_s_ready_out got %b exp 0", s_ready); end
    accept_out();
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_after got busy=%b m_valid=%b exp 0 0", busy, m_valid); end
  endtask

  task automatic test_majority;
    logic [31:0] d; logic e; int lat;
    run_record(3, 7'd2, 7'd2, 7'd3, 7'd0, 3'd1, 0, d, e, lat);
    checks++; if (d !== 32'h0000000F || lat !== 3) begin errors++; $display("FAIL majority_data got %h lat %0d exp 0000000f lat 3", d, lat); end
    accept_out();
    run_record(2, 7'd2, 7'd3, 7'd0, 7'd0, 3'd1, 0, d, e, lat);
    checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL majority_tie got %h err %b exp 00000000 err 0", d, e); end
    accept_out();
  endtask

  task automatic test_short;
    logic [31:0] d; logic e; int lat;
    run_record(2, 7'd0, 7'd1, 7'd0, 7'd0, 3'd3, 0, d, e, lat);
    checks++; if (d !== 32'h0 || e !== 1'b1 || lat !== 3) begin errors++; $display("FAIL short_err got %h err %b lat %0d exp 00000000 err 1 lat 3", d, e, lat); end
    accept_out();
  endtask

  task automatic test_clamp;
    logic [31:0] d; logic e; int lat;
    run_record(3, 7'd2, 7'd2, 7'd3, 7'd0, 3'd0, 0, d, e, lat);
    checks++; if (d !== 32'h0000000F) begin errors++; $display("FAIL clamp_low got %h exp 0000000f", d); end
    accept_out();
    run_record(4, 7'd0, 7'd0, 7'd0, 7'd0, 3'd7, 0, d, e, lat);
    checks++; if (d !== 32'h0000000F || e !== 1'b0) begin errors++; $display("FAIL clamp_high got %h err %b exp 0000000f err 0", d, e); end
    accept_out();
  endtask

  task automatic test_gaps;
    logic [31:0] d; logic e; int lat;
    run_record(2, 7'd0, 7'd1, 7'd0, 7'd0, 3'd2, 3, d, e, lat);
    checks++; if (d !== 32'h3 || lat !== 3) begin errors++; $display("FAIL gaps_data got %h lat %0d exp 00000003 lat 3", d, lat); end
    accept_out();
  endtask

  task automatic test_backpressure;
    logic [31:0] d; logic e; int lat;
    run_record(2, 7'd0, 7'd1, 7'd0, 7'd0, 3'd2, 0, d, e, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (m_data !== 32'h3 || m_valid !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d got data=%h v=%b rdy=%b busy=%b exp 00000003 1 0 1", c, m_data, m_valid, s_ready, busy);
      end
    end
    accept_out();
    checks++; if (busy !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL hold_release got busy=%b rdy=%b exp 0 1", busy, s_ready); end
  endtask

  task automatic test_abort;
    logic [31:0] d; logic e; int lat;
    bit seen;
    cfg_n = 3'd2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 7'(i); s_last = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (m_valid) seen = 1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_output got seen=%b busy=%b exp 0 0", seen, busy); end
    run_record(2, 7'd0, 7'd1, 7'd0, 7'd0, 3'd2, 0, d, e, lat);
    checks++; if (d !== 32'h3 || lat !== 3) begin errors++; $display("FAIL abort_next got %h lat %0d exp 00000003 lat 3", d, lat); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0 || m_data !== 32'h0) begin errors++; $display("FAIL abort_out got v=%b data=%h exp 0 00000000", m_valid, m_data); end
  endtask

  task automatic test_im_busy;
    logic [31:0] d; logic e; int lat;
    cfg_n = 3'd2;
    @(negedge clk);
    s_valid = 1'b1; s_data = 7'd0; s_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    im_we = 1'b1; im_addr = 7'd0; im_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    im_we = 1'b0;
    run_record(1, 7'd1, 7'd0, 7'd0, 7'd0, 3'd2, 0, d, e, lat);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL im_busy_record got %h exp 00000003", d); end
    accept_out();
    run_record(2, 7'd0, 7'd1, 7'd0, 7'd0, 3'd2, 0, d, e, lat);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL im_busy_dropped got %h exp 00000003", d); end
    accept_out();
  endtask

  task automatic test_same_cycle;
    logic [31:0] d; logic e; int lat;
    write_im(7'd4, 32'h00000080);
    cfg_n = 3'd1;
    @(negedge clk);
    im_we = 1'b1; im_addr = 7'd4; im_wdata = 32'h00000100;
    s_valid = 1'b1; s_data = 7'd4; s_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    im_we = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    lat = 0;
    while (!m_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (m_data !== 32'h00000080 || lat !== 3) begin errors++; $display("FAIL same_cycle_old got %h lat %0d exp 00000080 lat 3", m_data, lat); end
    accept_out();
    run_record(1, 7'd4, 7'd0, 7'd0, 7'd0, 3'd1, 0, d, e, lat);
    checks++; if (d !== 32'h00000100) begin errors++; $display("FAIL same_cycle_new got %h exp 00000100", d); end
    accept_out();
  endtask

  initial begin
    rst = 1'b1; cfg_n = 3'd1; im_we = 1'b0; im_addr = '0; im_wdata = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    test_reset();
    write_im(7'd0, 32'h00000001);
    write_im(7'd1, 32'h00000001);
    write_im(7'd2, 32'h0000000F);
    write_im(7'd3, 32'h000000F0);
    test_basic();
    test_majority();
    test_short();
    test_clamp();
    test_gaps();
    test_backpressure();
    test_abort();
    test_im_busy();
    test_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
